// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the multi-cycle multiply/divide unit.
//   MD_WIDTH  - default operand width
//   MD_CNT_W  - iteration counter width for the default operand width
//   md_op_e   - operation select (MULTU / DIVU)
//   md_state_e- control FSM states (IDLE / RUN / FIN)
package muldiv_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = $clog2(MD_WIDTH);

  typedef enum logic {
    OP_MULTU = 1'b0,
    OP_DIVU  = 1'b1
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/result bundle between the EX stage and the muldiv unit.
//   start/op/in1/in2   - request (driven by master)
//   busy/done          - handshake status (driven by slave)
//   hi/lo/divzero      - result registers (driven by slave)
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) ();

  logic             start;
  logic             op;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             divzero;

  modport master (
    output start, op, in1, in2,
    input  busy, done, hi, lo, divzero
  );

  modport slave (
    input  start, op, in1, in2,
    output busy, done, hi, lo, divzero
  );

endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the shift-add multiplier or
// the restoring divider.
//   op       - OP_MULTU / OP_DIVU
//   acc      - accumulator (MULTU) or partial remainder (DIVU), WIDTH+1 bits
//   sr       - multiplier (MULTU) or dividend/quotient (DIVU) shift register
//   opnd     - multiplicand (MULTU) or divisor (DIVU)
//   acc_nxt  - next accumulator / remainder
//   sr_nxt   - next shift register
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  md_op_e           op,
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] sr,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH:0]   acc_nxt,
  output logic [WIDTH-1:0] sr_nxt
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] shl_s;

  // Single iteration of the selected algorithm.
  always_comb begin
    acc_nxt = {(WIDTH+1){1'b0}};
    sr_nxt  = {WIDTH{1'b0}};
    sum_s   = {(WIDTH+1){1'b0}};
    shl_s   = {(WIDTH+1){1'b0}};
    case (op)
      OP_MULTU: begin
        // The extra accumulator bit keeps the carry so the right shift
        // brings it back into the upper half of the product.
        if (sr[0]) begin
          sum_s = acc + {1'b0, opnd};
        end else begin
          sum_s = acc;
        end
        {acc_nxt, sr_nxt} = {sum_s, sr} >> 1;
      end
      OP_DIVU: begin
        // Shift the next dividend bit into the remainder; the quotient
        // bit fills the slot vacated at the bottom of the shift register.
        shl_s = {acc[WIDTH-1:0], sr[WIDTH-1]};
        if (shl_s >= {1'b0, opnd}) begin
          acc_nxt = shl_s - {1'b0, opnd};
          sr_nxt  = {sr[WIDTH-2:0], 1'b1};
        end else begin
          acc_nxt = shl_s;
          sr_nxt  = {sr[WIDTH-2:0], 1'b0};
        end
      end
      default: begin
        acc_nxt = acc;
        sr_nxt  = sr;
      end
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative unsigned MULTU / DIVU with HI/LO result registers.
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - muldiv_if.slave: start/op/in1/in2 request, busy/done status,
//          hi/lo/divzero results
// A request is accepted in IDLE or FIN; a normal op spends WIDTH cycles in
// RUN, divide-by-zero skips RUN and completes on the accepting edge.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  md_state_e        state_r;
  md_state_e        state_nxt_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH:0]   acc_r;
  logic [WIDTH-1:0] sr_r;
  logic [WIDTH-1:0] opnd_r;
  md_op_e           op_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic             divzero_r;

  logic [WIDTH:0]   acc_nxt_s;
  logic [WIDTH-1:0] sr_nxt_s;
  logic             accept_s;
  logic             divzero_s;
  logic             last_s;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op      (op_r),
    .acc     (acc_r),
    .sr      (sr_r),
    .opnd    (opnd_r),
    .acc_nxt (acc_nxt_s),
    .sr_nxt  (sr_nxt_s)
  );

  // Request acceptance and completion decode.
  always_comb begin
    accept_s  = bus.start && ((state_r == IDLE) || (state_r == FIN));
    divzero_s = accept_s && (bus.op == 1'b1) && (bus.in2 == {WIDTH{1'b0}});
    last_s    = (state_r == RUN) && (cnt_r == CW'(WIDTH - 1));
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE, FIN: begin
        if (accept_s) begin
          state_nxt_s = divzero_s ? FIN : RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_nxt_s = FIN;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand capture and iteration datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r  <= {CW{1'b0}};
      acc_r  <= {(WIDTH+1){1'b0}};
      sr_r   <= {WIDTH{1'b0}};
      opnd_r <= {WIDTH{1'b0}};
      op_r   <= OP_MULTU;
    end else if (accept_s) begin
      cnt_r <= {CW{1'b0}};
      acc_r <= {(WIDTH+1){1'b0}};
      op_r  <= md_op_e'(bus.op);
      if (bus.op == 1'b1) begin
        sr_r   <= bus.in1;
        opnd_r <= bus.in2;
      end else begin
        sr_r   <= bus.in2;
        opnd_r <= bus.in1;
      end
    end else if (state_r == RUN) begin
      cnt_r <= cnt_r + CW'(1);
      acc_r <= acc_nxt_s;
      sr_r  <= sr_nxt_s;
    end
  end

  // Result registers: written only on a completion edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
      divzero_r <= 1'b0;
    end else if (divzero_s) begin
      hi_r      <= bus.in1;
      lo_r      <= {WIDTH{1'b1}};
      divzero_r <= 1'b1;
    end else if (last_s) begin
      // Both algorithms leave the high word in acc and the low word in sr.
      hi_r      <= acc_nxt_s[WIDTH-1:0];
      lo_r      <= sr_nxt_s;
      divzero_r <= 1'b0;
    end
  end

  assign bus.busy    = (state_r == RUN);
  assign bus.done    = (state_r == FIN);
  assign bus.hi      = hi_r;
  assign bus.lo      = lo_r;
  assign bus.divzero = divzero_r;

endmodule
